// File: rtl/cu_pkg.sv
// cu_pkg: states, instruction field codes, ALU opcodes and condition codes for the multicycle control unit
package cu_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXECR, S_EXECI, S_ALUWB, S_MEMADR,
    S_MEMRD, S_MEMWAIT, S_MEMWB, S_MEMWR, S_BRANCH
  } state_t;
  localparam logic [1:0] OP_DP = 2'b00, OP_MEM = 2'b01, OP_BR = 2'b10;
  localparam logic [3:0] CMD_AND = 4'b0000, CMD_SUB = 4'b0010, CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_ORR = 4'b1100, CMD_CMP = 4'b1010, CMD_MOV = 4'b1101;
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_ORR = 3'd3, ALU_MOV = 3'd4;
  localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE;
  function automatic logic [2:0] alu_op(input logic [3:0] cmd);
    return (cmd == CMD_SUB || cmd == CMD_CMP) ? ALU_SUB :
           (cmd == CMD_AND) ? ALU_AND :
           (cmd == CMD_ORR) ? ALU_ORR :
           (cmd == CMD_MOV) ? ALU_MOV : ALU_ADD;
  endfunction
endpackage

// File: rtl/cond_check.sv
// cond_check: ARM condition evaluation of cond against the NZCV register
module cond_check
  import cu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);
  logic n, z, c, v;
  assign {n, z, c, v} = flags;
  always_comb begin
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = !z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = !c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = !n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = !v;
      COND_HI: cond_ex = c && !z;
      COND_LS: cond_ex = !c || z;
      COND_GE: cond_ex = n == v;
      COND_LT: cond_ex = n != v;
      COND_GT: cond_ex = !z && (n == v);
      COND_LE: cond_ex = z || (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: multicycle ARM-subset control FSM with NZCV register; CU_BRANCH_LINK_EN enables BL link write
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int ALU_CTRL_W = 4,
  parameter int MEM_WAIT   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [19:0]           instruction,
  input  logic [3:0]            alu_flags,
  input  logic                  sh_imm,
  input  logic [1:0]            sh,
  output logic                  pc_write,
  output logic                  adr_src,
  output logic                  ir_write,
  output logic                  mem_write,
  output logic                  reg_write,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            result_src,
  output logic [1:0]            imm_src,
  output logic [1:0]            reg_src,
  output logic                  sh_src,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [3:0]            flags_q,
  output logic                  illegal
);
  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT - 1);
  state_t      state_q, state_d;
  logic [3:0]  flags_d, wait_q, wait_d;
  logic [3:0]  cond, cmd, rd;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [2:0]  op3;
  logic        cond_ex, cmd_ok, unused_bits;
  assign cond        = instruction[19:16];
  assign op          = instruction[15:14];
  assign funct       = instruction[13:8];
  assign rd          = instruction[3:0];
  assign cmd         = funct[4:1];
  assign cmd_ok      = cmd inside {CMD_AND, CMD_SUB, CMD_ADD, CMD_ORR, CMD_CMP, CMD_MOV};
  assign unused_bits = ^{instruction[7:4], sh};
  assign alu_control = ALU_CTRL_W'(op3);
  cond_check u_cond (.cond(cond), .flags(flags_q), .cond_ex(cond_ex));
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      flags_q <= 4'b0000;
      wait_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      wait_q  <= wait_d;
    end
  end
  always_comb begin
    state_d    = state_q;
    flags_d    = flags_q;
    wait_d     = wait_q;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'd0;
    alu_src_b  = 2'd0;
    result_src = 2'd0;
    imm_src    = 2'd0;
    reg_src    = 2'd0;
    sh_src     = 1'b1;
    op3        = ALU_ADD;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        alu_src_a  = 2'd1;
        alu_src_b  = 2'd2;
        result_src = 2'd2;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd2;
        illegal   = (op == 2'b11) || (op == OP_DP && !cmd_ok);
        state_d   = (op == OP_MEM) ? S_MEMADR :
                    (op == OP_BR) ? S_BRANCH :
                    (op == OP_DP && cmd_ok) ? (funct[5] ? S_EXECI : S_EXECR) : S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        alu_src_b = (state_q == S_EXECI) ? 2'd1 : 2'd0;
        op3       = alu_op(cmd);
        sh_src    = (cmd == CMD_MOV) ? sh_imm : 1'b1;
        flags_d   = !(funct[0] && cond_ex) ? flags_q :
                    (cmd inside {CMD_ADD, CMD_SUB, CMD_CMP}) ? alu_flags : {alu_flags[3:2], flags_q[1:0]};
        state_d   = (cmd == CMD_CMP) ? S_FETCH : S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = cond_ex;
        pc_write  = cond_ex && rd == 4'hF;
        state_d   = S_FETCH;
      end
      S_MEMADR: begin
        alu_src_b = 2'd1;
        imm_src   = 2'd1;
        op3       = funct[3] ? ALU_ADD : ALU_SUB;
        state_d   = funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        adr_src = 1'b1;
        state_d = (MEM_WAIT == 0) ? S_MEMWB : S_MEMWAIT;
      end
      S_MEMWAIT: begin
        adr_src = 1'b1;
        wait_d  = (wait_q == WAIT_LAST) ? 4'd0 : wait_q + 4'd1;
        state_d = (wait_q == WAIT_LAST) ? S_MEMWB : S_MEMWAIT;
      end
      S_MEMWB: begin
        result_src = 2'd1;
        reg_write  = cond_ex;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        adr_src   = 1'b1;
        mem_write = cond_ex;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        imm_src    = 2'd2;
        alu_src_a  = 2'd2;
        alu_src_b  = 2'd1;
        result_src = 2'd2;
        reg_src    = 2'd1;
        pc_write   = cond_ex;
        state_d    = S_FETCH;
`ifdef CU_BRANCH_LINK_EN
        if (funct[4] && cond_ex) begin
          reg_write  = 1'b1;
          reg_src    = 2'd2;
          result_src = 2'd0;
        end
`endif
      end
      default: state_d = S_FETCH;
    endcase
    if (!reset) {pc_write, ir_write, mem_write, reg_write, illegal} = 5'b0;
  end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: table-driven per-cycle output checks plus an asynchronous reset sequence
module tb_multicycle_control_unit;
  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_ORR = 4'd3, A_MOV = 4'd4;
  typedef struct packed {
    logic pw, as, iw, mw, rw, ill, shs;
    logic [1:0] sa, sb, rs, is, rgs;
    logic [3:0] ac, fl;
  } out_t;
  typedef struct {
    logic [19:0] ins;
    logic [3:0]  af;
    logic        shi;
    out_t        o;
  } vec_t;
  logic        clk, reset, sh_imm, pc_write, adr_src, ir_write, mem_write, reg_write, sh_src, illegal;
  logic [19:0] instruction;
  logic [3:0]  alu_flags, alu_control, flags_q;
  logic [1:0]  sh, alu_src_a, alu_src_b, result_src, imm_src, reg_src;
  int          n_cmp, n_bad;
  vec_t        vecs[$];
  out_t        act;
  multicycle_control_unit #(.ALU_CTRL_W(4), .MEM_WAIT(2)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .alu_flags(alu_flags),
    .sh_imm(sh_imm), .sh(sh), .pc_write(pc_write), .adr_src(adr_src), .ir_write(ir_write),
    .mem_write(mem_write), .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .imm_src(imm_src), .reg_src(reg_src), .sh_src(sh_src),
    .alu_control(alu_control), .flags_q(flags_q), .illegal(illegal)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic out_t base();
    out_t o = '0;
    o.shs = 1'b1;
    o.ac  = A_ADD;
    return o;
  endfunction
  function automatic out_t o_fetch();
    out_t o = base();
    o.pw = 1; o.iw = 1; o.sa = 2'd1; o.sb = 2'd2; o.rs = 2'd2;
    return o;
  endfunction
  function automatic out_t o_decode(input logic ill);
    out_t o = base();
    o.sa = 2'd1; o.sb = 2'd2; o.ill = ill;
    return o;
  endfunction
  function automatic out_t o_exec(input logic [1:0] sb, input logic [3:0] ac, input logic shs);
    out_t o = base();
    o.sb = sb; o.ac = ac; o.shs = shs;
    return o;
  endfunction
  function automatic out_t o_aluwb(input logic rw, input logic pw);
    out_t o = base();
    o.rw = rw; o.pw = pw;
    return o;
  endfunction
  function automatic out_t o_memadr(input logic [3:0] ac);
    out_t o = base();
    o.sb = 2'd1; o.is = 2'd1; o.ac = ac;
    return o;
  endfunction
  function automatic out_t o_memrd();
    out_t o = base();
    o.as = 1;
    return o;
  endfunction
  function automatic out_t o_memwb(input logic rw);
    out_t o = base();
    o.rs = 2'd1; o.rw = rw;
    return o;
  endfunction
  function automatic out_t o_memwr(input logic mw);
    out_t o = base();
    o.as = 1; o.mw = mw;
    return o;
  endfunction
  function automatic out_t o_branch(input logic pw, input logic link);
    out_t o = base();
    o.is = 2'd2; o.sa = 2'd2; o.sb = 2'd1; o.rs = 2'd2; o.pw = pw; o.rgs = 2'd1;
`ifdef CU_BRANCH_LINK_EN
    if (link && pw) begin
      o.rw = 1; o.rgs = 2'd2; o.rs = 2'd0;
    end
`else
    o.rw = link & 1'b0;
`endif
    return o;
  endfunction
  task automatic add(input logic [19:0] ins, input logic [3:0] af, input logic shi, input out_t o, input logic [3:0] fl);
    vec_t v;
    v.ins = ins; v.af = af; v.shi = shi; v.o = o; v.o.fl = fl;
    vecs.push_back(v);
  endtask
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask
  initial begin
    n_cmp = 0; n_bad = 0;
    reset = 1'b0; instruction = 20'h0; alu_flags = 4'h0; sh_imm = 1'b0; sh = 2'd0;
    add(20'hE2910, 4'h6, 0, o_fetch(), 4'h0);
    add(20'hE2910, 4'h6, 0, o_decode(0), 4'h0);
    add(20'hE2910, 4'h6, 0, o_exec(2'd1, A_ADD, 1), 4'h0);
    add(20'hE2910, 4'h6, 0, o_aluwb(1, 0), 4'h6);
    add(20'hE5921, 4'h0, 0, o_fetch(), 4'h6);
    add(20'hE5921, 4'h0, 0, o_decode(0), 4'h6);
    add(20'hE5921, 4'h0, 0, o_memadr(A_ADD), 4'h6);
    for (int i = 0; i < 3; i++) add(20'hE5921, 4'h0, 0, o_memrd(), 4'h6);
    add(20'hE5921, 4'h0, 0, o_memwb(1), 4'h6);
    add(20'hE5821, 4'h0, 0, o_fetch(), 4'h6);
    add(20'hE5821, 4'h0, 0, o_decode(0), 4'h6);
    add(20'hE5821, 4'h0, 0, o_memadr(A_ADD), 4'h6);
    add(20'hE5821, 4'h0, 0, o_memwr(1), 4'h6);
    add(20'h0A000, 4'h0, 0, o_fetch(), 4'h6);
    add(20'h0A000, 4'h0, 0, o_decode(0), 4'h6);
    add(20'h0A000, 4'h0, 0, o_branch(1, 0), 4'h6);
    add(20'hE3500, 4'h3, 0, o_fetch(), 4'h6);
    add(20'hE3500, 4'h3, 0, o_decode(0), 4'h6);
    add(20'hE3500, 4'h3, 0, o_exec(2'd1, A_SUB, 1), 4'h6);
    add(20'h0A000, 4'h0, 0, o_fetch(), 4'h3);
    add(20'h0A000, 4'h0, 0, o_decode(0), 4'h3);
    add(20'h0A000, 4'h0, 0, o_branch(0, 0), 4'h3);
    add(20'hE0102, 4'hC, 0, o_fetch(), 4'h3);
    add(20'hE0102, 4'hC, 0, o_decode(0), 4'h3);
    add(20'hE0102, 4'hC, 0, o_exec(2'd0, A_AND, 1), 4'h3);
    add(20'hE0102, 4'hC, 0, o_aluwb(1, 0), 4'hF);
    add(20'h10803, 4'h0, 0, o_fetch(), 4'hF);
    add(20'h10803, 4'h0, 0, o_decode(0), 4'hF);
    add(20'h10803, 4'h0, 0, o_exec(2'd0, A_ADD, 1), 4'hF);
    add(20'h10803, 4'h0, 0, o_aluwb(0, 0), 4'hF);
    add(20'hE280F, 4'h0, 0, o_fetch(), 4'hF);
    add(20'hE280F, 4'h0, 0, o_decode(0), 4'hF);
    add(20'hE280F, 4'h0, 0, o_exec(2'd1, A_ADD, 1), 4'hF);
    add(20'hE280F, 4'h0, 0, o_aluwb(1, 1), 4'hF);
    add(20'hE2401, 4'h0, 0, o_fetch(), 4'hF);
    add(20'hE2401, 4'h0, 0, o_decode(0), 4'hF);
    add(20'hE2401, 4'h0, 0, o_exec(2'd1, A_SUB, 1), 4'hF);
    add(20'hE2401, 4'h0, 0, o_aluwb(1, 0), 4'hF);
    add(20'hE3801, 4'h0, 0, o_fetch(), 4'hF);
    add(20'hE3801, 4'h0, 0, o_decode(0), 4'hF);
    add(20'hE3801, 4'h0, 0, o_exec(2'd1, A_ORR, 1), 4'hF);
    add(20'hE3801, 4'h0, 0, o_aluwb(1, 0), 4'hF);
    add(20'hE1A01, 4'h0, 0, o_fetch(), 4'hF);
    add(20'hE1A01, 4'h0, 0, o_decode(0), 4'hF);
    add(20'hE1A01, 4'h0, 0, o_exec(2'd0, A_MOV, 0), 4'hF);
    add(20'hE1A01, 4'h0, 0, o_aluwb(1, 0), 4'hF);
    add(20'hE5121, 4'h0, 0, o_fetch(), 4'hF);
    add(20'hE5121, 4'h0, 0, o_decode(0), 4'hF);
    add(20'hE5121, 4'h0, 0, o_memadr(A_SUB), 4'hF);
    for (int i = 0; i < 3; i++) add(20'hE5121, 4'h0, 0, o_memrd(), 4'hF);
    add(20'hE5121, 4'h0, 0, o_memwb(1), 4'hF);
    add(20'hF2801, 4'h0, 0, o_fetch(), 4'hF);
    add(20'hF2801, 4'h0, 0, o_decode(0), 4'hF);
    add(20'hF2801, 4'h0, 0, o_exec(2'd1, A_ADD, 1), 4'hF);
    add(20'hF2801, 4'h0, 0, o_aluwb(0, 0), 4'hF);
    add(20'hEC000, 4'h0, 0, o_fetch(), 4'hF);
    add(20'hEC000, 4'h0, 0, o_decode(1), 4'hF);
    add(20'hE0200, 4'h0, 0, o_fetch(), 4'hF);
    add(20'hE0200, 4'h0, 0, o_decode(1), 4'hF);
    add(20'hEB000, 4'h0, 0, o_fetch(), 4'hF);
    add(20'hEB000, 4'h0, 0, o_decode(0), 4'hF);
    add(20'hEB000, 4'h0, 0, o_branch(1, 1), 4'hF);
    #12;
    check("rst_enables", {27'd0, pc_write, ir_write, mem_write, reg_write, illegal}, 32'd0);
    check("rst_flags", {28'd0, flags_q}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    foreach (vecs[i]) begin
      instruction = vecs[i].ins;
      alu_flags   = vecs[i].af;
      sh_imm      = vecs[i].shi;
      #1;
      act = {pc_write, adr_src, ir_write, mem_write, reg_write, illegal, sh_src,
             alu_src_a, alu_src_b, result_src, imm_src, reg_src, alu_control, flags_q};
      n_cmp++;
      if (act !== vecs[i].o) begin
        n_bad++;
        $display("FAIL row%0d ins=%h: got %b expected %b", i, vecs[i].ins, act, vecs[i].o);
      end
      @(negedge clk);
    end
    instruction = 20'hE5821;
    alu_flags   = 4'h0;
    repeat (3) @(negedge clk);
    #1;
    check("memwr_before_reset", {31'd0, mem_write}, 32'd1);
    #1 reset = 1'b0;
    #1;
    check("reset_mid_memwr_enables", {28'd0, pc_write, ir_write, mem_write, reg_write}, 32'd0);
    check("reset_mid_memwr_flags", {28'd0, flags_q}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("post_reset_fetch", {29'd0, ir_write, pc_write, adr_src}, 32'd6);
    @(negedge clk);
    #1;
    check("post_reset_decode", {29'd0, ir_write, pc_write, mem_write}, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
